af_stream_throttle: RTL and testbench

AF_STREAM_THROTTLE -- requirements
Module: af_stream_throttle

---
 rtl/af_stream_throttle_if.sv | 22 ++
 rtl/af_stream_throttle.sv | 82 ++++++++
 tb/tb_af_stream_throttle.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/af_stream_throttle_if.sv
// Stream bundle between an upstream producer, the throttle and a downstream FIFO
// that only signals almost_full (no ready return path).
interface af_stream_throttle_if #(
   parameter int DATA_WIDTH = 512
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  almost_full;

   modport master (
      output in_data, in_valid, almost_full,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, almost_full,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/af_stream_throttle.sv
// Small circular buffer that meters a stream into a FIFO using only its almost_full flag,
// with saturating counters for issued beats and stalled cycles.
module af_stream_throttle #(
   parameter int DATA_WIDTH = 512,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                reset,
   af_stream_throttle_if.slave strm,
   output logic [31:0]         xfer_cnt,
   output logic [31:0]         stall_cnt
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg;
   logic [PTR_W-1:0]      rd_ptr_reg;
   logic [PTR_W:0]        count_reg;
   logic                  af_q_reg;
   logic                  out_valid_reg;
   logic [DATA_WIDTH-1:0] out_data_reg;
   logic [31:0]           xfer_cnt_reg;
   logic [31:0]           stall_cnt_reg;
   logic                  ready;
   logic                  push;
   logic                  pop;

   // Ready depends only on registered occupancy, so a full buffer refuses a push
   // even when a pop happens on the same edge.
   assign ready = (count_reg < DEPTH_C);
   assign push  = strm.in_valid && ready;
   assign pop   = (count_reg != '0) && !af_q_reg;

   assign strm.in_ready  = ready;
   assign strm.out_valid = out_valid_reg;
   assign strm.out_data  = out_data_reg;
   assign xfer_cnt       = xfer_cnt_reg;
   assign stall_cnt      = stall_cnt_reg;

   // Storage and output data carry no reset so they map onto plain RAM/registers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= strm.in_data;
      end
      if (pop) begin
         out_data_reg <= mem[rd_ptr_reg];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         af_q_reg      <= 1'b1;
         out_valid_reg <= 1'b0;
         xfer_cnt_reg  <= '0;
         stall_cnt_reg <= '0;
      end else begin
         af_q_reg      <= strm.almost_full;
         out_valid_reg <= pop;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (out_valid_reg && (xfer_cnt_reg != '1)) begin
            xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
         end
         if ((count_reg != '0) && af_q_reg && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_af_stream_throttle.sv
// Directed bench for af_stream_throttle: accepted beats feed a scoreboard queue that
// a negedge monitor drains whenever out_valid is seen.
module tb_af_stream_throttle;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] xfer_cnt;
   logic [31:0] stall_cnt;

   af_stream_throttle_if #(.DATA_WIDTH(DW)) sif ();

   af_stream_throttle #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .strm      (sif),
      .xfer_cnt  (xfer_cnt),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            beats    = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] next_data;

   // Monitor: checks every output beat against the scoreboard, then records acceptances.
   always @(negedge clk) begin
      logic [DW-1:0] exp_d;
      if (sif.out_valid) begin
         beats++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: actual out_data=%h, required no beat", sif.out_data);
         end else begin
            exp_d = exp_q.pop_front();
            if (sif.out_data !== exp_d) begin
               n_fail++;
               $display("FAIL beat_data: actual out_data=%h, required %h", sif.out_data, exp_d);
            end else begin
               $display("beat %0d out_data=%h", beats, sif.out_data);
            end
         end
      end
      if (!reset && sif.in_valid && sif.in_ready) begin
         exp_q.push_back(sif.in_data);
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok %s = %0h", name, act);
      end
   endtask

   // One cycle of continuous offering; the payload advances only when accepted.
   task automatic stream_cycle();
      logic r;
      sif.in_valid = 1'b1;
      sif.in_data  = next_data;
      r = sif.in_ready;
      cycle();
      if (r) next_data = next_data + 1;
   endtask

   initial begin
      int acc;
      int drops;
      int b0;
      int afb;
      int late;
      logic [31:0] s0;
      logic r;

      sif.in_valid    = 1'b0;
      sif.in_data     = '0;
      sif.almost_full = 1'b0;
      next_data       = 32'h0000_C000;

      // Reset state
      repeat (3) cycle();
      check("rst_out_valid", sif.out_valid, 0);
      check("rst_xfer_cnt", xfer_cnt, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_in_ready", sif.in_ready, 1);
      reset = 1'b0;

      // Single beat: pushed on edge E, visible after edge E+1
      sif.in_valid = 1'b1;
      sif.in_data  = 32'h0000_00A5;
      cycle();
      sif.in_valid = 1'b0;
      check("single_not_early", sif.out_valid, 0);
      cycle();
      check("single_out_valid", sif.out_valid, 1);
      check("single_out_data", sif.out_data, 32'hA5);
      cycle();
      check("single_one_beat", sif.out_valid, 0);
      check("single_xfer_cnt", xfer_cnt, 1);

      // Fill under almost_full
      sif.almost_full = 1'b1;
      cycle();
      cycle();
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         sif.in_valid = 1'b1;
         sif.in_data  = 32'h0000_00B0 + acc;
         r = sif.in_ready;
         cycle();
         if (r) acc++;
      end
      sif.in_valid = 1'b0;
      check("fill_accepted", acc, 4);
      check("fill_in_ready_low", sif.in_ready, 0);
      s0 = stall_cnt;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("fill_stall_inc", stall_cnt, s0 + i + 1);
      end
      sif.almost_full = 1'b0;
      cycle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("fill_drain_consecutive", sif.out_valid, 1);
      end
      cycle();
      check("fill_drain_done", sif.out_valid, 0);
      check("fill_in_ready_back", sif.in_ready, 1);
      check("fill_xfer_cnt", xfer_cnt, 5);

      // Streaming from a clean state
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      exp_q.delete();
      cycle();
      cycle();
      b0 = beats;
      drops = 0;
      for (int i = 0; i < 100; i++) begin
         sif.in_valid = 1'b1;
         sif.in_data  = 32'h0000_1000 + i;
         if (!sif.in_ready) drops++;
         cycle();
      end
      sif.in_valid = 1'b0;
      repeat (4) cycle();
      check("stream_ready_drops", drops, 0);
      check("stream_beats", beats - b0, 100);
      check("stream_xfer_cnt", xfer_cnt, 100);
      check("stream_stall_cnt", stall_cnt, 0);

      // Backpressure bound while streaming
      repeat (10) stream_cycle();
      sif.almost_full = 1'b1;
      afb  = sif.out_valid ? 1 : 0;
      late = 0;
      for (int k = 0; k < 10; k++) begin
         stream_cycle();
         if (sif.out_valid) begin
            afb++;
            if (k >= 2) late++;
         end
      end
      check("bp_at_most_two", (afb <= 2), 1);
      check("bp_none_after", late, 0);
      check("bp_in_ready_full", sif.in_ready, 0);
      sif.almost_full = 1'b0;
      repeat (12) stream_cycle();
      sif.in_valid = 1'b0;
      repeat (8) cycle();
      check("bp_drained", exp_q.size(), 0);

      // Reset with beats buffered
      sif.almost_full = 1'b1;
      cycle();
      cycle();
      for (int i = 0; i < 3; i++) begin
         sif.in_valid = 1'b1;
         sif.in_data  = 32'h0000_00D0 + i;
         cycle();
      end
      sif.in_valid = 1'b0;
      cycle();
      reset = 1'b1;
      cycle();
      exp_q.delete();
      reset = 1'b0;
      check("midrst_out_valid", sif.out_valid, 0);
      check("midrst_xfer_cnt", xfer_cnt, 0);
      check("midrst_stall_cnt", stall_cnt, 0);
      check("midrst_in_ready", sif.in_ready, 1);
      sif.almost_full = 1'b0;
      b0 = beats;
      repeat (6) cycle();
      check("midrst_no_old_beats", beats - b0, 0);

      // Stall counter saturation
      sif.almost_full = 1'b1;
      cycle();
      sif.in_valid = 1'b1;
      sif.in_data  = 32'h0000_00E0;
      cycle();
      sif.in_valid = 1'b0;
      cycle();
      force dut.stall_cnt_reg = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_reg;
      repeat (3) cycle();
      check("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
      sif.almost_full = 1'b0;
      repeat (5) cycle();
      check("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
